// File: rtl/skin_frame_ctrl_pkg.sv
// Shared types and default geometry for the skin frame controller.
package skin_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_CW    = 10;

endpackage

// File: rtl/skin_bbox_accum.sv
// Skin pixel counter and bounding-box tracker for one frame.
// Outputs show the running totals including this cycle's en/skin input.
module skin_bbox_accum #(
  parameter int CW = 10
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            en,
  input  logic            skin,
  input  logic [CW-1:0]   x,
  input  logic [CW-1:0]   y,
  output logic [2*CW-1:0] count,
  output logic [CW-1:0]   xmin,
  output logic [CW-1:0]   xmax,
  output logic [CW-1:0]   ymin,
  output logic [CW-1:0]   ymax
);

  logic [2*CW-1:0] count_reg;
  logic [CW-1:0]   xmin_reg, xmax_reg, ymin_reg, ymax_reg;
  logic            hit;

  assign hit = en & skin;

  always_comb begin
    count = count_reg;
    xmin  = xmin_reg;
    xmax  = xmax_reg;
    ymin  = ymin_reg;
    ymax  = ymax_reg;
    if (hit) begin
      if (count_reg != '1) count = count_reg + (2*CW)'(1);
      // Count never returns to zero once it has moved, so zero means "no skin yet".
      if (count_reg == '0) begin
        xmin = x;
        xmax = x;
        ymin = y;
        ymax = y;
      end else begin
        if (x < xmin_reg) xmin = x;
        if (x > xmax_reg) xmax = x;
        if (y < ymin_reg) ymin = y;
        if (y > ymax_reg) ymax = y;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      xmin_reg  <= '1;
      xmax_reg  <= '0;
      ymin_reg  <= '1;
      ymax_reg  <= '0;
    end else if (clear) begin
      count_reg <= '0;
      xmin_reg  <= '1;
      xmax_reg  <= '0;
      ymin_reg  <= '1;
      ymax_reg  <= '0;
    end else begin
      count_reg <= count;
      xmin_reg  <= xmin;
      xmax_reg  <= xmax;
      ymin_reg  <= ymin;
      ymax_reg  <= ymax;
    end
  end

endmodule

// File: rtl/skin_frame_ctrl.sv
// Frame controller: walks pixels through an external skin classifier and reports
// per-frame count/bounding box. Define SKIN_FRAME_ERR_EN for mid-frame SOF checking.
module skin_frame_ctrl
  import skin_frame_ctrl_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int CW       = DEF_CW
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_sof,
  input  logic [BITWIDTH-1:0] s_red,
  input  logic [BITWIDTH-1:0] s_green,
  input  logic [BITWIDTH-1:0] s_blue,
  input  logic [2*CW-1:0]     cfg_min_count,
  output logic                pix_valid,
  output logic [BITWIDTH-1:0] pix_red,
  output logic [BITWIDTH-1:0] pix_green,
  output logic [BITWIDTH-1:0] pix_blue,
  input  logic                class_skin,
  output logic                stat_valid,
  output logic [2*CW-1:0]     stat_count,
  output logic [CW-1:0]       stat_xmin,
  output logic [CW-1:0]       stat_xmax,
  output logic [CW-1:0]       stat_ymin,
  output logic [CW-1:0]       stat_ymax,
  output logic                stat_detect
`ifdef SKIN_FRAME_ERR_EN
  ,
  output logic                frame_err
`endif
);

  localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(IMG_H - 1);

  state_t          state;
  logic [CW-1:0]   x_reg, y_reg, pix_x_reg, pix_y_reg;
  logic [2*CW-1:0] min_count_reg;

  logic            hs, restart, start, accept, last, x_wrap;
  logic [CW-1:0]   cur_x, cur_y, next_x, next_y;

  logic [2*CW-1:0] acc_count;
  logic [CW-1:0]   acc_xmin, acc_xmax, acc_ymin, acc_ymax;

  // x_reg/y_reg hold the coordinate the next accepted pixel will take.
  always_comb begin
    hs      = s_valid & s_ready;
    restart = 1'b0;
`ifdef SKIN_FRAME_ERR_EN
    restart = hs & s_sof & (state == ACTIVE);
`endif
    start   = (hs & s_sof & (state == IDLE)) | restart;
    accept  = start | (hs & (state == ACTIVE));
    cur_x   = start ? '0 : x_reg;
    cur_y   = start ? '0 : y_reg;
    x_wrap  = (cur_x == X_LAST);
    last    = accept & x_wrap & (cur_y == Y_LAST);
    next_x  = x_wrap ? '0 : cur_x + CW'(1);
    next_y  = x_wrap ? cur_y + CW'(1) : cur_y;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      s_ready       <= 1'b0;
      x_reg         <= '0;
      y_reg         <= '0;
      pix_x_reg     <= '0;
      pix_y_reg     <= '0;
      min_count_reg <= '0;
      pix_valid     <= 1'b0;
      pix_red       <= '0;
      pix_green     <= '0;
      pix_blue      <= '0;
      stat_valid    <= 1'b0;
      stat_count    <= '0;
      stat_xmin     <= '0;
      stat_xmax     <= '0;
      stat_ymin     <= '0;
      stat_ymax     <= '0;
      stat_detect   <= 1'b0;
`ifdef SKIN_FRAME_ERR_EN
      frame_err     <= 1'b0;
`endif
    end else begin
      pix_valid  <= accept;
      stat_valid <= 1'b0;
      if (accept) begin
        pix_red   <= s_red;
        pix_green <= s_green;
        pix_blue  <= s_blue;
        pix_x_reg <= cur_x;
        pix_y_reg <= cur_y;
        x_reg     <= next_x;
        y_reg     <= next_y;
      end
      if (start) min_count_reg <= cfg_min_count;
`ifdef SKIN_FRAME_ERR_EN
      if (restart) frame_err <= 1'b1;
`endif
      case (state)
        IDLE, ACTIVE: begin
          if (last) begin
            state   <= FLUSH;
            s_ready <= 1'b0;
          end else begin
            if (accept) state <= ACTIVE;
            s_ready <= 1'b1;
          end
        end
        FLUSH: begin
          // The last pixel's verdict is folded in by the accumulator's pass-through view.
          state       <= REPORT;
          stat_valid  <= 1'b1;
          stat_count  <= acc_count;
          stat_xmin   <= acc_xmin;
          stat_xmax   <= acc_xmax;
          stat_ymin   <= acc_ymin;
          stat_ymax   <= acc_ymax;
          stat_detect <= (acc_count >= min_count_reg);
        end
        REPORT: begin
          state   <= IDLE;
          s_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  skin_bbox_accum #(
    .CW(CW)
  ) u_accum (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start),
    .en      (pix_valid),
    .skin    (class_skin),
    .x       (pix_x_reg),
    .y       (pix_y_reg),
    .count   (acc_count),
    .xmin    (acc_xmin),
    .xmax    (acc_xmax),
    .ymin    (acc_ymin),
    .ymax    (acc_ymax)
  );

endmodule

// File: tb/tb_skin_frame_ctrl.sv
// Bench for skin_frame_ctrl on a 4x2 image with a frame-level reference model.
module tb_skin_frame_ctrl;

  localparam int BW = 8;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int CW = 10;
`ifdef SKIN_FRAME_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              s_sof = 1'b0;
  logic [BW-1:0]     s_red = '0, s_green = '0, s_blue = '0;
  logic [2*CW-1:0]   cfg_min_count = 20'd2;
  logic              pix_valid;
  logic [BW-1:0]     pix_red, pix_green, pix_blue;
  logic              class_skin;
  logic              stat_valid;
  logic [2*CW-1:0]   stat_count;
  logic [CW-1:0]     stat_xmin, stat_xmax, stat_ymin, stat_ymax;
  logic              stat_detect;
`ifdef SKIN_FRAME_ERR_EN
  logic              frame_err;
`endif

  int errors = 0;
  int checks = 0;
  int report_cnt = 0;

  always #5 clock = ~clock;

  // Stand-in classifier: a pixel is skin when its red MSB is set.
  assign class_skin = pix_red[7];

  skin_frame_ctrl #(
    .BITWIDTH(BW), .IMG_W(W), .IMG_H(H), .CW(CW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_sof         (s_sof),
    .s_red         (s_red),
    .s_green       (s_green),
    .s_blue        (s_blue),
    .cfg_min_count (cfg_min_count),
    .pix_valid     (pix_valid),
    .pix_red       (pix_red),
    .pix_green     (pix_green),
    .pix_blue      (pix_blue),
    .class_skin    (class_skin),
    .stat_valid    (stat_valid),
    .stat_count    (stat_count),
    .stat_xmin     (stat_xmin),
    .stat_xmax     (stat_xmax),
    .stat_ymin     (stat_ymin),
    .stat_ymax     (stat_ymax),
    .stat_detect   (stat_detect)
`ifdef SKIN_FRAME_ERR_EN
    ,
    .frame_err     (frame_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] fr_q[$];
  bit          m_in_frame = 0, m_ready = 0, m_pv = 0, m_sv = 0, m_det = 0, m_err = 0;
  logic [7:0]  m_pr = 0, m_pg = 0, m_pb = 0;
  int          m_cnt = 0, m_xmn = 0, m_xmx = 0, m_ymn = 0, m_ymx = 0;
  int          p_cnt, p_xmn, p_xmx, p_ymn, p_ymx;
  bit          p_det;
  int          m_min = 0, m_gap = 0;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_in_frame = 0; m_ready = 0; m_pv = 0; m_sv = 0; m_err = 0; m_gap = 0;
      m_pr = 0; m_pg = 0; m_pb = 0;
      m_cnt = 0; m_xmn = 0; m_xmx = 0; m_ymn = 0; m_ymx = 0; m_det = 0;
      fr_q.delete();
    end else begin
      bit hs;
      hs = s_valid && m_ready;
      m_pv = 0;
      m_sv = 0;
      if (m_gap == 2) begin
        m_gap = 1;
        m_sv = 1;
        m_cnt = p_cnt; m_xmn = p_xmn; m_xmx = p_xmx; m_ymn = p_ymn; m_ymx = p_ymx; m_det = p_det;
      end else begin
        m_gap = 0;
        m_ready = 1;
      end
      if (hs) begin
        if (s_sof && (!m_in_frame || ERR_EN)) begin
          if (m_in_frame) m_err = 1;
          m_in_frame = 1;
          fr_q.delete();
          m_min = int'(cfg_min_count);
        end
        if (m_in_frame) begin
          fr_q.push_back({s_red, s_green, s_blue});
          m_pv = 1; m_pr = s_red; m_pg = s_green; m_pb = s_blue;
          if (fr_q.size() == W * H) begin
            p_cnt = 0; p_xmn = 1023; p_xmx = 0; p_ymn = 1023; p_ymx = 0;
            for (int i = 0; i < W * H; i++) begin
              if (fr_q[i][23]) begin
                p_cnt++;
                if (i % W < p_xmn) p_xmn = i % W;
                if (i % W > p_xmx) p_xmx = i % W;
                if (i / W < p_ymn) p_ymn = i / W;
                if (i / W > p_ymx) p_ymx = i / W;
              end
            end
            p_det = (p_cnt >= m_min);
            m_in_frame = 0;
            m_gap = 2;
            m_ready = 0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clock);
    chk("s_ready", 32'(s_ready), 32'(m_ready));
    chk("pix_valid", 32'(pix_valid), 32'(m_pv));
    if (m_pv) begin
      chk("pix_red", 32'(pix_red), 32'(m_pr));
      chk("pix_green", 32'(pix_green), 32'(m_pg));
      chk("pix_blue", 32'(pix_blue), 32'(m_pb));
    end
    chk("stat_valid", 32'(stat_valid), 32'(m_sv));
    chk("stat_count", 32'(stat_count), m_cnt);
    chk("stat_xmin", 32'(stat_xmin), m_xmn);
    chk("stat_xmax", 32'(stat_xmax), m_xmx);
    chk("stat_ymin", 32'(stat_ymin), m_ymn);
    chk("stat_ymax", 32'(stat_ymax), m_ymx);
    chk("stat_detect", 32'(stat_detect), 32'(m_det));
`ifdef SKIN_FRAME_ERR_EN
    chk("frame_err", 32'(frame_err), 32'(m_err));
`endif
  end

  initial forever begin
    @(negedge clock);
    if (stat_valid === 1'b1) begin
      report_cnt++;
      $display("report %0d: count=%0d x=%0d..%0d y=%0d..%0d detect=%0d", report_cnt,
               stat_count, stat_xmin, stat_xmax, stat_ymin, stat_ymax, stat_detect);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic sof, input logic skin, input int gap);
    bit ok;
    repeat (gap) begin
      s_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    s_valid = 1'b1;
    s_sof   = sof;
    s_red   = skin ? (8'h80 | 8'($urandom_range(0, 127))) : 8'($urandom_range(0, 127));
    s_green = 8'($urandom);
    s_blue  = 8'($urandom);
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      logic acc;
      @(negedge clock);
      acc = s_ready;
      @(posedge clock);
      #1;
      if (acc) begin
        ok = 1;
        break;
      end
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    chk("handshake", 32'(ok), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] mask, input int gap, input int extra_sof);
    for (int i = 0; i < 8; i++) push(i == 0 || i == extra_sof, mask[i], gap);
  endtask

  task automatic expect_report(input string name, input int rc0, input int cnt, input int xmn,
                               input int xmx, input int ymn, input int ymx, input int det);
    repeat (4) @(posedge clock);
    #1;
    chk({name, "_reports"}, report_cnt - rc0, 1);
    chk({name, "_count"}, 32'(stat_count), cnt);
    chk({name, "_xmin"}, 32'(stat_xmin), xmn);
    chk({name, "_xmax"}, 32'(stat_xmax), xmx);
    chk({name, "_ymin"}, 32'(stat_ymin), ymn);
    chk({name, "_ymax"}, 32'(stat_ymax), ymx);
    chk({name, "_detect"}, 32'(stat_detect), det);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int rc0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_stat_valid", 32'(stat_valid), 0);
    chk("rst_stat_count", 32'(stat_count), 0);
    reset_n = 1'b1;

    // Basic frame: skin at (1,0) and (2,1)
    rc0 = report_cnt;
    send_frame(8'b0100_0010, 0, -1);
    expect_report("basic", rc0, 2, 1, 2, 0, 1, 1);

    // No skin
    rc0 = report_cnt;
    send_frame(8'b0000_0000, 0, -1);
    expect_report("empty", rc0, 0, 1023, 0, 1023, 0, 0);

    // No skin but zero threshold: detect still true
    cfg_min_count = 20'd0;
    rc0 = report_cnt;
    send_frame(8'b0000_0000, 1, -1);
    expect_report("empty_min0", rc0, 0, 1023, 0, 1023, 0, 1);
    cfg_min_count = 20'd2;

    // Valid toggling every cycle
    rc0 = report_cnt;
    send_frame(8'b0100_0010, 1, -1);
    expect_report("toggle", rc0, 2, 1, 2, 0, 1, 1);

    // Leading non-SOF pixels in IDLE are dropped
    rc0 = report_cnt;
    repeat (3) push(1'b0, 1'b1, 0);
    send_frame(8'b0100_0010, 0, -1);
    expect_report("lead_drop", rc0, 2, 1, 2, 0, 1, 1);

    // Reset after 5 pixels, then a full frame
    for (int i = 0; i < 5; i++) push(i == 0, 1'b1, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("midrst_s_ready", 32'(s_ready), 0);
    chk("midrst_pix_valid", 32'(pix_valid), 0);
    chk("midrst_stat_count", 32'(stat_count), 0);
    chk("midrst_stat_xmin", 32'(stat_xmin), 0);
    reset_n = 1'b1;
    rc0 = report_cnt;
    send_frame(8'b1000_0001, 0, -1);
    expect_report("after_rst", rc0, 2, 0, 3, 0, 1, 1);

    // SOF on the fourth pixel of a frame
    rc0 = report_cnt;
    for (int i = 0; i < 3; i++) push(i == 0, 1'b1, 0);
    send_frame(8'b0000_0100, 0, -1);
`ifdef SKIN_FRAME_ERR_EN
    expect_report("sof_mid", rc0, 1, 2, 2, 0, 0, 0);
    chk("sof_mid_frame_err", 32'(frame_err), 1);
`else
    expect_report("sof_mid", rc0, 4, 0, 2, 0, 1, 1);
`endif

    // Randomized traffic
    rc0 = report_cnt;
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) push(1'b0, 1'($urandom), $urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        cfg_min_count = 20'($urandom_range(0, 6));
        push(i == 0 || $urandom_range(0, 19) == 0, 1'($urandom), $urandom_range(0, 2));
        if ($urandom_range(0, 59) == 0) begin
          reset_n = 1'b0;
          @(posedge clock);
          #1;
          reset_n = 1'b1;
        end
      end
    end
    repeat (5) @(posedge clock);
    #1;
    chk("random_reports_seen", 32'(report_cnt - rc0 >= 10), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
